sprite_render: RTL and testbench

- Pixel-pipeline stage directly downstream of dvi_controller and upstream of the DVI Pmod output registers.
- Consumes sx/sy/hsync/vsync/de and draws one scaled 1-bpp bitmap sprite over a flat background.
- Emits 4-bit RGB with syncs delay-matched to the colour path.
- Sprite position is latched once per frame; bitmap rows are writable at run time.

---
 rtl/sprite_render.sv | 252 +++++++++++++++++++++++++
 tb/tb_sprite_render.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_render.sv
// ---------------------------------------------------------------------------
// sprite_render
//
// Pixel-pipeline stage that draws one scaled 1-bpp bitmap sprite over a flat
// background. It sits between the sync generator and the DVI output
// registers. Colour and syncs leave the block exactly two pixel clocks after
// the matching sx/sy/sync inputs.
//
// Ports:
//   clk_pix, rst_pix        pixel clock, synchronous active-high reset
//   sx, sy                  current screen coordinate from the sync generator
//   hsync_i, vsync_i, de_i  syncs / data enable from the sync generator
//   pos_x, pos_y, pos_valid requested sprite top-left corner; sampled only on
//                           the first vertical blanking line (sx==0, sy==V_RES)
//   bmp_we, bmp_addr,       bitmap row write port; bmp_data MSB is the
//   bmp_data                leftmost sprite pixel
//   hsync_o, vsync_o, de_o  sync inputs delayed by two cycles
//   r, g, b                 4-bit colour aligned with de_o
//   sprite_hit              output pixel is a set sprite bit
// ---------------------------------------------------------------------------
module sprite_render #(
    parameter int          CORDW      = 10,
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter int          SPR_W      = 16,
    parameter int          SPR_H      = 8,
    parameter int          SCALE_LOG2 = 1,
    parameter int          INIT_X     = 312,
    parameter int          INIT_Y     = 232,
    parameter logic [11:0] FG_COLR    = 12'hFFF,
    parameter logic [11:0] BG_COLR    = 12'h137
) (
    input  logic                     clk_pix,
    input  logic                     rst_pix,
    input  logic [CORDW-1:0]         sx,
    input  logic [CORDW-1:0]         sy,
    input  logic                     hsync_i,
    input  logic                     vsync_i,
    input  logic                     de_i,
    input  logic [CORDW-1:0]         pos_x,
    input  logic [CORDW-1:0]         pos_y,
    input  logic                     pos_valid,
    input  logic                     bmp_we,
    input  logic [$clog2(SPR_H)-1:0] bmp_addr,
    input  logic [SPR_W-1:0]         bmp_data,
    output logic                     hsync_o,
    output logic                     vsync_o,
    output logic                     de_o,
    output logic [3:0]               r,
    output logic [3:0]               g,
    output logic [3:0]               b,
    output logic                     sprite_hit
);

    localparam int RW = $clog2(SPR_H);
    localparam int CW = $clog2(SPR_W);
    // Keep the sub-pixel counter at least one bit wide so SCALE_LOG2=0 works.
    localparam int SW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

    localparam logic [SW-1:0]  SUB_LAST = SW'((1 << SCALE_LOG2) - 1);
    localparam logic [CW-1:0]  COL_LAST = CW'(SPR_W - 1);
    localparam logic [CORDW:0] SPR_SPAN = (CORDW + 1)'(SPR_H << SCALE_LOG2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [11:0] pix_colour(input logic de, input logic set);
        if (!de)
            return 12'h000;
        else if (set)
            return FG_COLR;
        else
            return BG_COLR;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [SW-1:0]    sub_q, sub_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CORDW-1:0] px_q, px_d;
    logic [CORDW-1:0] py_q, py_d;
    logic [SPR_W-1:0] bmp_q [SPR_H];
    logic [SPR_W-1:0] bmp_d [SPR_H];

    logic hs_p1_q, hs_p1_d;
    logic vs_p1_q, vs_p1_d;
    logic de_p1_q, de_p1_d;
    logic bit_p1_q, bit_p1_d;

    logic        hs_p2_q, hs_p2_d;
    logic        vs_p2_q, vs_p2_d;
    logic        de_p2_q, de_p2_d;
    logic [11:0] rgb_p2_q, rgb_p2_d;
    logic        hit_p2_q, hit_p2_d;

    // ------------------------------------------------------------------
    // Line evaluation for the current input pixel (stage 0)
    // ------------------------------------------------------------------
    logic             line_start;
    logic [CORDW:0]   sy_ext, py_ext, dy;
    logic             in_rows;
    logic             px_on_screen;
    logic             armed_now;
    logic             start_draw;
    logic             draw_now;
    logic [CW-1:0]    col_now;
    logic [SW-1:0]    sub_now;
    logic [RW-1:0]    row_now;
    logic [SPR_W-1:0] row_bits;
    logic             bit_now;

    always_comb begin
        line_start   = (sx == '0);
        sy_ext       = {1'b0, sy};
        py_ext       = {1'b0, py_q};
        dy           = sy_ext - py_ext;
        // One extra bit so a sprite near the bottom never wraps to the top.
        in_rows      = (sy_ext >= py_ext) && (sy_ext < (py_ext + SPR_SPAN));
        // A sprite anchored in horizontal blanking can never become visible.
        px_on_screen = ({1'b0, px_q} < (CORDW + 1)'(H_RES));

        // sx==0 re-evaluates the line whatever the current state is.
        armed_now  = line_start ? in_rows : (state_q == ST_ARMED);
        // The pixel at sx==px is itself the first drawn pixel.
        start_draw = armed_now && (sx == px_q) && px_on_screen;
        draw_now   = start_draw || (!line_start && (state_q == ST_DRAW));

        col_now  = start_draw ? '0 : col_q;
        sub_now  = start_draw ? '0 : sub_q;
        row_now  = line_start ? RW'(dy >> SCALE_LOG2) : row_q;
        row_bits = bmp_q[row_now];
        bit_now  = draw_now && row_bits[COL_LAST - col_now];
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        sub_d   = sub_q;
        row_d   = row_now;

        if (draw_now) begin
            if ((col_now == COL_LAST) && (sub_now == SUB_LAST)) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_DRAW;
                if (sub_now == SUB_LAST) begin
                    sub_d = '0;
                    col_d = col_now + 1'b1;
                end else begin
                    sub_d = sub_now + 1'b1;
                    col_d = col_now;
                end
            end
        end else if (armed_now) begin
            state_d = ST_ARMED;
        end else if (line_start) begin
            state_d = ST_IDLE;
        end
    end

    // Position only moves on the first blanking line, so a frame never tears.
    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (line_start && (sy == CORDW'(V_RES)) && pos_valid) begin
            px_d = pos_x;
            py_d = pos_y;
        end
    end

    always_comb begin
        for (int i = 0; i < SPR_H; i++)
            bmp_d[i] = bmp_q[i];
        if (bmp_we && (int'(bmp_addr) < SPR_H))
            bmp_d[bmp_addr] = bmp_data;
    end

    // ------------------------------------------------------------------
    // Stage 0 -> stage 1: sprite bit and syncs
    // ------------------------------------------------------------------
    always_comb begin
        hs_p1_d  = hsync_i;
        vs_p1_d  = vsync_i;
        de_p1_d  = de_i;
        bit_p1_d = bit_now;
    end

    // ------------------------------------------------------------------
    // Stage 1 -> stage 2: colour resolve
    // ------------------------------------------------------------------
    always_comb begin
        hs_p2_d  = hs_p1_q;
        vs_p2_d  = vs_p1_q;
        de_p2_d  = de_p1_q;
        rgb_p2_d = pix_colour(de_p1_q, bit_p1_q);
        hit_p2_d = de_p1_q && bit_p1_q;
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            sub_q    <= '0;
            row_q    <= '0;
            px_q     <= CORDW'(INIT_X);
            py_q     <= CORDW'(INIT_Y);
            for (int i = 0; i < SPR_H; i++)
                bmp_q[i] <= '0;
            hs_p1_q  <= 1'b0;
            vs_p1_q  <= 1'b0;
            de_p1_q  <= 1'b0;
            bit_p1_q <= 1'b0;
            hs_p2_q  <= 1'b0;
            vs_p2_q  <= 1'b0;
            de_p2_q  <= 1'b0;
            rgb_p2_q <= '0;
            hit_p2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            sub_q    <= sub_d;
            row_q    <= row_d;
            px_q     <= px_d;
            py_q     <= py_d;
            for (int i = 0; i < SPR_H; i++)
                bmp_q[i] <= bmp_d[i];
            hs_p1_q  <= hs_p1_d;
            vs_p1_q  <= vs_p1_d;
            de_p1_q  <= de_p1_d;
            bit_p1_q <= bit_p1_d;
            hs_p2_q  <= hs_p2_d;
            vs_p2_q  <= vs_p2_d;
            de_p2_q  <= de_p2_d;
            rgb_p2_q <= rgb_p2_d;
            hit_p2_q <= hit_p2_d;
        end
    end

    assign hsync_o    = hs_p2_q;
    assign vsync_o    = vs_p2_q;
    assign de_o       = de_p2_q;
    assign r          = rgb_p2_q[11:8];
    assign g          = rgb_p2_q[7:4];
    assign b          = rgb_p2_q[3:0];
    assign sprite_hit = hit_p2_q;

endmodule

// File: tb/tb_sprite_render.sv
module tb_sprite_render;

    localparam int HT = 800;

    logic        clk_pix = 1'b0;
    logic        rst_pix;
    logic [9:0]  sx, sy;
    logic        hsync_i, vsync_i, de_i;
    logic [9:0]  pos_x, pos_y;
    logic        pos_valid;
    logic        bmp_we;
    logic [2:0]  bmp_addr;
    logic [15:0] bmp_data;
    logic        hsync_o, vsync_o, de_o;
    logic [3:0]  r, g, b;
    logic        sprite_hit;

    always #5 clk_pix = ~clk_pix;

    sprite_render dut (
        .clk_pix    (clk_pix),
        .rst_pix    (rst_pix),
        .sx         (sx),
        .sy         (sy),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .de_i       (de_i),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_valid  (pos_valid),
        .bmp_we     (bmp_we),
        .bmp_addr   (bmp_addr),
        .bmp_data   (bmp_data),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .de_o       (de_o),
        .r          (r),
        .g          (g),
        .b          (b),
        .sprite_hit (sprite_hit)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] s_rgb;
    logic        s_hit;
    logic [2:0]  s_sync;
    logic [11:0] rgb_a  [HT];
    logic        hit_a  [HT];
    logic [2:0]  sync_a [HT];

    // 640x480 timing: {hsync, vsync, de}, syncs active low.
    function automatic logic [2:0] sync_in(input int x, input int y);
        logic hs, vs, de;
        hs = !(x >= 656 && x < 752);
        vs = !(y == 490 || y == 491);
        de = (x < 640) && (y < 480);
        return {hs, vs, de};
    endfunction

    // Sample outputs of the previous edge, then drive the next pixel.
    task automatic cyc(input int x, input int y);
        @(negedge clk_pix);
        s_rgb  = {r, g, b};
        s_hit  = sprite_hit;
        s_sync = {hsync_o, vsync_o, de_o};
        sx = 10'(x);
        sy = 10'(y);
        {hsync_i, vsync_i, de_i} = sync_in(x, y);
    endtask

    // Runs one full line; result arrays are indexed by the input sx.
    task automatic run_line(input int y);
        for (int i = 0; i < HT + 2; i++) begin
            cyc(i, y);
            if (i >= 2) begin
                rgb_a[i-2]  = s_rgb;
                hit_a[i-2]  = s_hit;
                sync_a[i-2] = s_sync;
            end
        end
    endtask

    task automatic write_row(input int a, input logic [15:0] d);
        bmp_we   = 1'b1;
        bmp_addr = 3'(a);
        bmp_data = d;
        cyc(801, 0);
        bmp_we   = 1'b0;
    endtask

    task automatic latch_pos(input int x, input int y);
        pos_valid = 1'b1;
        pos_x     = 10'(x);
        pos_y     = 10'(y);
        run_line(480);
        pos_valid = 1'b0;
    endtask

    task automatic test_reset;
        int errs;
        rst_pix = 1'b1;
        repeat (3) cyc(801, 0);
        cyc(801, 0);
        n_cmp++;
        if (s_rgb !== 12'h000) begin n_bad++; $display("FAIL reset_rgb got %h want 000", s_rgb); end
        n_cmp++;
        if (s_hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit got %b want 0", s_hit); end
        n_cmp++;
        if (s_sync !== 3'b000) begin n_bad++; $display("FAIL reset_sync got %b want 000", s_sync); end
        rst_pix = 1'b0;

        // Draw part of a line with a full row at the reset position.
        write_row(0, 16'hFFFF);
        for (int x = 0; x <= 320; x++) cyc(x, 232);
        n_cmp++;
        if (s_hit !== 1'b1 || s_rgb !== 12'hFFF) begin
            n_bad++; $display("FAIL prereset_pix sx318 got hit=%b rgb=%h want 1 FFF", s_hit, s_rgb);
        end
        rst_pix = 1'b1;
        cyc(321, 232);
        n_cmp++;
        if (s_rgb !== 12'h000 || s_hit !== 1'b0 || s_sync !== 3'b000) begin
            n_bad++; $display("FAIL midline_reset got rgb=%h hit=%b sync=%b want 000 0 000", s_rgb, s_hit, s_sync);
        end
        cyc(322, 232);
        cyc(323, 232);
        rst_pix = 1'b0;
        for (int x = 324; x < HT + 2; x++) cyc(x, 232);

        // Bitmap is cleared: sprite rows show only background.
        for (int y = 232; y < 248; y++) begin
            run_line(y);
            errs = 0;
            for (int x = 0; x < HT; x++) begin
                if (hit_a[x] !== 1'b0) errs++;
                if (rgb_a[x] !== ((x < 640) ? 12'h137 : 12'h000)) errs++;
            end
            n_cmp++;
            if (errs !== 0) begin n_bad++; $display("FAIL postreset_line sy=%0d bad pixels %0d want 0", y, errs); end
        end
    endtask

    task automatic test_basic;
        int errs;
        logic eh;
        write_row(0, 16'h8001);
        run_line(232);
        n_cmp++;
        if (hit_a[312] !== 1'b1 || hit_a[313] !== 1'b1 || hit_a[342] !== 1'b1 || hit_a[343] !== 1'b1) begin
            n_bad++; $display("FAIL init_pos_hits got %b%b%b%b want 1111", hit_a[312], hit_a[313], hit_a[342], hit_a[343]);
        end
        n_cmp++;
        if (hit_a[311] !== 1'b0 || hit_a[314] !== 1'b0 || rgb_a[314] !== 12'h137 || rgb_a[312] !== 12'hFFF) begin
            n_bad++; $display("FAIL init_pos_edges got hit311=%b hit314=%b rgb314=%h rgb312=%h want 0 0 137 FFF",
                              hit_a[311], hit_a[314], rgb_a[314], rgb_a[312]);
        end

        latch_pos(100, 50);
        for (int y = 49; y <= 52; y++) begin
            run_line(y);
            errs = 0;
            for (int x = 0; x < HT; x++) begin
                eh = (y == 50 || y == 51) && (x == 100 || x == 101 || x == 130 || x == 131);
                if (hit_a[x] !== eh) errs++;
                if (rgb_a[x] !== ((x >= 640) ? 12'h000 : (eh ? 12'hFFF : 12'h137))) errs++;
            end
            n_cmp++;
            if (errs !== 0) begin n_bad++; $display("FAIL basic_line sy=%0d bad pixels %0d want 0", y, errs); end
        end
    endtask

    task automatic test_sync;
        int errs, errc;
        int lines [3] = '{479, 480, 490};
        for (int k = 0; k < 3; k++) begin
            run_line(lines[k]);
            errs = 0;
            errc = 0;
            for (int x = 0; x < HT; x++) begin
                if (sync_a[x] !== sync_in(x, lines[k])) errs++;
                if (sync_in(x, lines[k]) & 3'b001) begin
                    if (rgb_a[x] !== 12'h137) errc++;
                end else if (rgb_a[x] !== 12'h000 || hit_a[x] !== 1'b0) errc++;
            end
            n_cmp++;
            if (errs !== 0) begin n_bad++; $display("FAIL sync_delay sy=%0d bad samples %0d want 0", lines[k], errs); end
            n_cmp++;
            if (errc !== 0) begin n_bad++; $display("FAIL blank_colour sy=%0d bad samples %0d want 0", lines[k], errc); end
        end
    endtask

    task automatic test_midframe;
        int errs;
        logic eh;
        pos_valid = 1'b1;
        pos_x = 10'd200;
        pos_y = 10'd200;
        run_line(100);
        pos_valid = 1'b0;
        run_line(50);
        n_cmp++;
        if (hit_a[100] !== 1'b1 || hit_a[131] !== 1'b1) begin
            n_bad++; $display("FAIL midframe_ignored got hit100=%b hit131=%b want 1 1", hit_a[100], hit_a[131]);
        end
        run_line(200);
        n_cmp++;
        if (hit_a[200] !== 1'b0) begin n_bad++; $display("FAIL midframe_early got hit200=%b want 0", hit_a[200]); end

        latch_pos(200, 200);
        run_line(200);
        errs = 0;
        for (int x = 0; x < HT; x++) begin
            eh = (x == 200 || x == 201 || x == 230 || x == 231);
            if (hit_a[x] !== eh) errs++;
        end
        n_cmp++;
        if (errs !== 0) begin n_bad++; $display("FAIL moved_line sy=200 bad pixels %0d want 0", errs); end
        run_line(50);
        n_cmp++;
        if (hit_a[100] !== 1'b0 || rgb_a[100] !== 12'h137) begin
            n_bad++; $display("FAIL old_pos_cleared got hit=%b rgb=%h want 0 137", hit_a[100], rgb_a[100]);
        end
    endtask

    task automatic test_right_edge;
        int errs;
        logic eh;
        write_row(0, 16'hFFFF);
        latch_pos(630, 10);
        for (int y = 10; y <= 12; y++) begin
            run_line(y);
            errs = 0;
            for (int x = 0; x < HT; x++) begin
                eh = (y != 12) && (x >= 630) && (x <= 639);
                if (hit_a[x] !== eh) errs++;
                if (rgb_a[x] !== ((x >= 640) ? 12'h000 : (eh ? 12'hFFF : 12'h137))) errs++;
            end
            n_cmp++;
            if (errs !== 0) begin n_bad++; $display("FAIL right_edge sy=%0d bad pixels %0d want 0", y, errs); end
        end
    endtask

    task automatic test_bottom;
        int errs;
        int lines [4] = '{0, 1, 10, 11};
        latch_pos(0, 1020);
        for (int k = 0; k < 4; k++) begin
            run_line(lines[k]);
            errs = 0;
            for (int x = 0; x < HT; x++)
                if (hit_a[x] !== 1'b0) errs++;
            n_cmp++;
            if (errs !== 0) begin n_bad++; $display("FAIL bottom_wrap sy=%0d hit pixels %0d want 0", lines[k], errs); end
        end
    endtask

    initial begin
        rst_pix   = 1'b1;
        sx        = '0;
        sy        = '0;
        hsync_i   = 1'b1;
        vsync_i   = 1'b1;
        de_i      = 1'b0;
        pos_x     = '0;
        pos_y     = '0;
        pos_valid = 1'b0;
        bmp_we    = 1'b0;
        bmp_addr  = '0;
        bmp_data  = '0;

        test_reset;
        test_basic;
        test_sync;
        test_midframe;
        test_right_edge;
        test_bottom;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
